// File: rtl/i2s_pkg.sv
// Shared types and frame geometry for the I2S microphone receiver.
// No logic; constants only.
// Imported by the clock generator and the receiver top.
package i2s_pkg;

  // Slot selected for capture: left is WS low, right is WS high.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int BIT_CNT_W  = 6;

endpackage

// File: rtl/i2s_clkgen.sv
// Purpose: I2S bit clock / word select generator with a rise strobe for the receiver.
// Latency: sck toggles one clk after the divider's terminal count; strobes are combinational.
// Backpressure: none; en_i=0 parks sck/ws low and restarts at frame start.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  output logic                 sck_o,
  output logic                 ws_o,
  output logic                 rise_o,
  output logic [BIT_CNT_W-2:0] slot_bit_o
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     r_div_cnt;
  logic                 r_sck;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 w_tc;
  logic                 w_fall;

  // Terminal count only while running, so the strobes are silent when parked.
  assign w_tc       = en_i && (r_div_cnt == DIV_LAST);
  assign rise_o     = w_tc && !r_sck;
  assign w_fall     = w_tc && r_sck;
  assign sck_o      = r_sck;
  assign ws_o       = r_bit_cnt[BIT_CNT_W-1];
  assign slot_bit_o = r_bit_cnt[BIT_CNT_W-2:0];

  // Divider and bit clock: toggle sck at each terminal count, park low when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (!en_i) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
      r_sck     <= ~r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Frame position advances on each sck falling edge; the MSB is WS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if (!en_i) begin
      r_bit_cnt <= '0;
    end else if (w_fall) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_mic_rx.sv
// Purpose: I2S master receiver; keeps the top SAMPLE_WIDTH bits of one slot per frame.
// Latency: sample presented one clk after the sck rise that carries its last kept bit.
// Backpressure: one-entry buffer; a commit into a full, unready buffer drops the word and sets overrun.
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int       CLK_DIV      = 4,
  parameter int       SAMPLE_WIDTH = 16,
  parameter channel_e CHANNEL      = CH_LEFT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    sd_i,
  output logic                    sck_o,
  output logic                    ws_o,
  output logic                    lr_o,
  output logic [SAMPLE_WIDTH-1:0] sample_o,
  output logic                    sample_valid_o,
  input  logic                    sample_ready_i,
  output logic                    overrun_o,
  input  logic                    overrun_clr_i
);

  // The shifter holds all kept bits but the last; the last is taken live from the input flop.
  localparam int         SH_W     = (SAMPLE_WIDTH > 1) ? SAMPLE_WIDTH - 1 : 1;
  localparam logic [4:0] LAST_BIT = 5'(SAMPLE_WIDTH);
  localparam logic       SEL_WS   = (CHANNEL == CH_RIGHT);

  logic                    w_rise;
  logic                    w_ws;
  logic [4:0]              w_slot_bit;
  logic                    w_hit;
  logic                    w_commit;
  logic                    w_accept;
  logic [SAMPLE_WIDTH-1:0] w_word;

  logic                    r_sd;
  logic [SH_W-1:0]         r_shift;
  logic [SAMPLE_WIDTH-1:0] r_sample;
  logic                    r_valid;
  logic                    r_overrun;

  i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .sck_o      (sck_o),
    .ws_o       (w_ws),
    .rise_o     (w_rise),
    .slot_bit_o (w_slot_bit)
  );

  // Slot bit 0 is the I2S one-bit delay and is never kept.
  assign w_hit    = w_rise && (w_ws == SEL_WS) && (w_slot_bit != 5'd0) && (w_slot_bit <= LAST_BIT);
  assign w_commit = w_hit && (w_slot_bit == LAST_BIT);
  assign w_accept = r_valid && sample_ready_i;

  // Completed word includes the bit being captured on this rise.
  if (SAMPLE_WIDTH > 1) begin : g_word_wide
    assign w_word = {r_shift, r_sd};
  end else begin : g_word_one
    assign w_word = r_sd;
  end

  assign ws_o           = w_ws;
  assign lr_o           = SEL_WS;
  assign sample_o       = r_sample;
  assign sample_valid_o = r_valid;
  assign overrun_o      = r_overrun;

  // Input flop on the asynchronous serial data line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sd <= 1'b0;
    end else begin
      r_sd <= sd_i;
    end
  end

  // Deserialiser: shift MSB-first on selected-slot rises; disabling drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (!en_i) begin
      r_shift <= '0;
    end else if (w_hit) begin
      r_shift <= w_word[SH_W-1:0];
    end
  end

  // Output buffer: load on commit when empty or being drained, otherwise hold until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else if (w_commit && (!r_valid || sample_ready_i)) begin
      r_sample <= w_word;
      r_valid  <= 1'b1;
    end else if (w_accept && !w_commit) begin
      r_valid  <= 1'b0;
    end
  end

  // Sticky drop flag; a new drop in the clear cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_commit && r_valid && !sample_ready_i) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr_i) begin
      r_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: a mic model drives SD from the DUT's SCK/WS, a scoreboard
// holds the expected samples, and monitors compare whenever a sample is handed over.
// A second instance captures the right slot against a constant right-channel word.
module tb_i2s_mic_rx;
  import i2s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic sd    = 1'b0;
  logic ready = 1'b1;
  logic clr   = 1'b0;
  logic r_rdy = 1'b1;
  logic r_clr = 1'b0;

  logic        sck_l, ws_l, lr_l, vld_l, ovr_l;
  logic [15:0] dat_l;
  logic        sck_r, ws_r, lr_r, vld_r, ovr_r;
  logic [15:0] dat_r;

  i2s_mic_rx #(.CLK_DIV(4), .SAMPLE_WIDTH(16), .CHANNEL(CH_LEFT)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .sd_i(sd),
    .sck_o(sck_l), .ws_o(ws_l), .lr_o(lr_l),
    .sample_o(dat_l), .sample_valid_o(vld_l), .sample_ready_i(ready),
    .overrun_o(ovr_l), .overrun_clr_i(clr)
  );

  i2s_mic_rx #(.CLK_DIV(4), .SAMPLE_WIDTH(16), .CHANNEL(CH_RIGHT)) dut_r (
    .clk(clk), .rst_n(rst_n), .en_i(en), .sd_i(sd),
    .sck_o(sck_r), .ws_o(ws_r), .lr_o(lr_r),
    .sample_o(dat_r), .sample_valid_o(vld_r), .sample_ready_i(r_rdy),
    .overrun_o(ovr_r), .overrun_clr_i(r_clr)
  );

  localparam int M_EXP  = 0;  // word will be delivered and checked
  localparam int M_LOST = 1;  // word dropped (overrun) or cut off (reset / disable)

  typedef struct { logic [23:0] w; int mode; } word_t;
  typedef struct { bit chk; logic [15:0] v; } exp_t;

  word_t left_q[$];
  exp_t  exp_q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int bfm_pos = 0;
  logic        last_ws = 1'b0;
  logic [23:0] cur_left = 24'h0;
  logic [23:0] cur_right = 24'h7FFF00;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [23:0] w, input int mode);
    word_t e;
    e.w = w;
    e.mode = mode;
    left_q.push_back(e);
  endtask

  // Mic model: shifts a new bit out 1 ns after each SCK fall; MSB one SCK after WS changes.
  always @(negedge sck_l) begin
    #1;
    if (rst_n && en) begin
      if (ws_l != last_ws) bfm_pos = 0;
      else bfm_pos = bfm_pos + 1;
      last_ws = ws_l;
      if (!ws_l && bfm_pos == 1) begin
        exp_t x;
        if (left_q.size() != 0) begin
          word_t e;
          e = left_q.pop_front();
          cur_left = e.w;
          if (e.mode == M_EXP) begin
            x.chk = 1'b1;
            x.v = e.w[23:8];
            exp_q.push_back(x);
          end
        end else begin
          cur_left = 24'h0;
          x.chk = 1'b0;
          x.v = 16'h0;
          exp_q.push_back(x);
        end
      end
      if (bfm_pos >= 1 && bfm_pos <= 24)
        sd = ws_l ? cur_right[24 - bfm_pos] : cur_left[24 - bfm_pos];
      else
        sd = 1'b0;
    end
  end

  always @(negedge rst_n or negedge en) begin
    bfm_pos = 0;
    last_ws = 1'b0;
    sd = 1'b0;
  end

  // Left monitor: every handed-over sample pops one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && vld_l && ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_sample: got %0h, expected no sample", dat_l);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if (x.chk) check("left_sample", {16'h0, dat_l}, {16'h0, x.v});
      end
    end
  end

  // Right monitor: right slot always carries 0x7FFF00.
  always @(negedge clk) begin
    if (rst_n && vld_r && r_rdy) check("right_sample", {16'h0, dat_r}, 32'h7FFF);
  end

  task automatic wait_accept(input string name);
    int c0;
    int k;
    c0 = acc_cnt;
    k = 0;
    while (acc_cnt == c0 && k < 2000) begin tick(1); k++; end
    if (k >= 2000) timeout_fail(name);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((left_q.size() != 0 || exp_q.size() != 0) && k < 4000) begin tick(1); k++; end
    if (k >= 4000) timeout_fail(name);
  endtask

  task automatic wait_left_pos(input logic [23:0] w, input int pos, input string name);
    int k;
    k = 0;
    while (!(bfm_pos == pos && !ws_l && cur_left == w) && k < 4000) begin tick(1); k++; end
    if (k >= 4000) timeout_fail(name);
  endtask

  initial begin
    int c1, c2, k, n;
    logic bad;

    // Reset state
    tick(3);
    check("rst_sck", sck_l, 0);
    check("rst_ws", ws_l, 0);
    check("rst_sample", dat_l, 0);
    check("rst_valid", vld_l, 0);
    check("rst_overrun", ovr_l, 0);
    check("lr_left", lr_l, 0);
    check("lr_right", lr_r, 1);
    rst_n = 1'b1;
    tick(2);
    en = 1'b1;

    // 1: basic capture and timing
    push(24'hA5F0C3, M_EXP);
    push(24'h123456, M_EXP);
    push(24'hFEDCBA, M_EXP);
    k = 0;
    while (sck_l && k < 100) begin tick(1); k++; end
    while (!sck_l && k < 100) begin tick(1); k++; end
    c1 = cyc;
    while (sck_l && k < 100) begin tick(1); k++; end
    while (!sck_l && k < 100) begin tick(1); k++; end
    c2 = cyc;
    if (k >= 100) timeout_fail("t1_sck");
    else check("t1_sck_period", c2 - c1, 8);
    k = 0;
    while (!ws_l && k < 1000) begin tick(1); k++; end
    c1 = cyc;
    while (ws_l && k < 1000) begin tick(1); k++; end
    c2 = cyc;
    if (k >= 1000) timeout_fail("t1_ws");
    else check("t1_ws_half", c2 - c1, 256);
    wait_accept("t1_acc_a");
    c1 = cyc;
    wait_accept("t1_acc_b");
    c2 = cyc;
    check("t1_valid_spacing", c2 - c1, 512);
    drain("t1_drain");

    // 2: left zero, right full-scale positive
    push(24'h000000, M_EXP);
    push(24'h000000, M_EXP);
    push(24'h000000, M_EXP);
    drain("t2_drain");

    // 3: consumer stalls for three frames
    wait_accept("t3_sync");
    ready = 1'b0;
    push(24'h111111, M_EXP);
    push(24'h222222, M_LOST);
    push(24'h333333, M_LOST);
    push(24'h444444, M_EXP);
    tick(1700);
    check("t3_hold_sample", dat_l, 16'h1111);
    check("t3_hold_valid", vld_l, 1);
    check("t3_overrun", ovr_l, 1);
    ready = 1'b1;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    check("t3_overrun_clr", ovr_l, 0);
    drain("t3_drain");

    // 4: ready only in the commit cycle of a full buffer
    wait_accept("t4_sync");
    ready = 1'b0;
    push(24'h555555, M_EXP);
    push(24'h666666, M_EXP);
    wait_left_pos(24'h666666, 16, "t4_pos");
    tick(3);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(1);
    check("t4_new_sample", dat_l, 16'h6666);
    check("t4_valid", vld_l, 1);
    check("t4_no_overrun", ovr_l, 0);
    ready = 1'b1;
    drain("t4_drain");

    // 5: asynchronous reset mid left slot
    push(24'h777777, M_LOST);
    push(24'h888888, M_EXP);
    wait_left_pos(24'h777777, 9, "t5_pos");
    rst_n = 1'b0;
    #1;
    check("t5_sck", sck_l, 0);
    check("t5_ws", ws_l, 0);
    check("t5_sample", dat_l, 0);
    check("t5_valid", vld_l, 0);
    check("t5_overrun", ovr_l, 0);
    tick(5);
    rst_n = 1'b1;
    drain("t5_drain");

    // 6: disable mid left slot
    push(24'h999999, M_LOST);
    push(24'hAAAAAA, M_EXP);
    wait_left_pos(24'h999999, 9, "t6_pos");
    en = 1'b0;
    tick(1);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sck_l || ws_l || vld_l) bad = 1'b1;
      tick(1);
    end
    check("t6_parked", bad, 0);
    en = 1'b1;
    n = 0;
    while (!ws_l && n < 400) begin tick(1); n++; end
    check("t6_ws_low_cycles", n, 256);
    drain("t6_drain");

    tick(600);
    check("right_no_overrun", ovr_r, 0);
    check("left_no_overrun", ovr_l, 0);
    check("scoreboard_empty", left_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
